// File: rtl/pipe_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mem_wb_stage
//  Purpose  : MEM stage and MEM/WB pipeline register. Data RAM plus
//             memory-mapped I/O; optional misaligned-access trap enabled
//             by defining MISALIGN_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_wb_stage #(
    parameter int DEPTH_LOG2 = 5,
    parameter int IO_BIT     = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic        merr
);

    localparam int c_ram_depth = 1 << DEPTH_LOG2;

    logic [31:0]           ram_mem [c_ram_depth];

    logic                  w_io;
    logic [DEPTH_LOG2-1:0] w_ram_idx;
    logic [1:0]            w_io_off;
    logic                  w_misalign;
    logic                  w_store_ram;
    logic                  w_store_io;
    logic [31:0]           w_rd_data;
    logic                  w_unused_malu;

    logic        wwreg_d,     wwreg_q;
    logic        wm2reg_d,    wm2reg_q;
    logic [31:0] wmo_d,       wmo_q;
    logic [31:0] walu_d,      walu_q;
    logic [4:0]  wrn_d,       wrn_q;
    logic [31:0] out_port0_d, out_port0_q;
    logic [31:0] out_port1_d, out_port1_q;
    logic        merr_d,      merr_q;

    assign w_io          = malu[IO_BIT];
    assign w_ram_idx     = malu[DEPTH_LOG2+1:2];
    assign w_io_off      = malu[3:2];
    // High address bits alias onto the RAM; they are deliberately ignored.
    assign w_unused_malu = ^malu;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (mwmem | mm2reg) && (malu[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_store_ram = mwmem & ~w_misalign & ~w_io;
    assign w_store_io  = mwmem & ~w_misalign &  w_io;

    // Read-first: the RAM word is taken before this edge's write lands.
    always_comb begin
        w_rd_data = ram_mem[w_ram_idx];
        if (w_io) begin
            case (w_io_off)
                2'd0:    w_rd_data = out_port0_q;
                2'd1:    w_rd_data = out_port1_q;
                2'd2:    w_rd_data = in_port0;
                default: w_rd_data = in_port1;
            endcase
        end
    end

    always_comb begin
        wwreg_d     = mwreg & ~w_misalign;
        wm2reg_d    = mm2reg;
        wmo_d       = w_rd_data;
        walu_d      = malu;
        wrn_d       = mrn;
        out_port0_d = out_port0_q;
        out_port1_d = out_port1_q;
        if (w_store_io && (w_io_off == 2'd0)) begin
            out_port0_d = mb;
        end
        if (w_store_io && (w_io_off == 2'd1)) begin
            out_port1_d = mb;
        end
`ifdef MISALIGN_TRAP_EN
        merr_d = merr_q | w_misalign;
`else
        merr_d = 1'b0;
`endif
    end

    // RAM has no reset; contents survive resetn, but a store in a reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (resetn && w_store_ram) begin
            ram_mem[w_ram_idx] <= mb;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wwreg_q     <= 1'b0;
            wm2reg_q    <= 1'b0;
            wmo_q       <= 32'd0;
            walu_q      <= 32'd0;
            wrn_q       <= 5'd0;
            out_port0_q <= 32'd0;
            out_port1_q <= 32'd0;
            merr_q      <= 1'b0;
        end else begin
            wwreg_q     <= wwreg_d;
            wm2reg_q    <= wm2reg_d;
            wmo_q       <= wmo_d;
            walu_q      <= walu_d;
            wrn_q       <= wrn_d;
            out_port0_q <= out_port0_d;
            out_port1_q <= out_port1_d;
            merr_q      <= merr_d;
        end
    end

    assign wwreg     = wwreg_q;
    assign wm2reg    = wm2reg_q;
    assign wmo       = wmo_q;
    assign walu      = walu_q;
    assign wrn       = wrn_q;
    assign out_port0 = out_port0_q;
    assign out_port1 = out_port1_q;
    assign merr      = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_mem_wb_stage
//  Purpose  : Scoreboard bench for pipe_mem_wb_stage; directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_wb_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic [31:0] in_port0, in_port1;
    logic        wwreg, wm2reg, merr;
    logic [31:0] wmo, walu, out_port0, out_port1;
    logic [4:0]  wrn;

    pipe_mem_wb_stage #(.DEPTH_LOG2(5), .IO_BIT(7)) dut (
        .clock(clock), .resetn(resetn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .in_port0(in_port0), .in_port1(in_port1),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
        .out_port0(out_port0), .out_port1(out_port1), .merr(merr)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic        chk_wmo;
        logic [31:0] walu;
        logic [4:0]  wrn;
        logic [31:0] op0;
        logic [31:0] op1;
        logic        merr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit c_trap = 1'b1;
`else
    localparam bit c_trap = 1'b0;
`endif

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every registered output set is compared against the queued entry.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "wwreg",     {31'd0, wwreg},  {31'd0, e.wwreg});
            chk(e.name, "wm2reg",    {31'd0, wm2reg}, {31'd0, e.wm2reg});
            chk(e.name, "walu",      walu,            e.walu);
            chk(e.name, "wrn",       {27'd0, wrn},    {27'd0, e.wrn});
            chk(e.name, "out_port0", out_port0,       e.op0);
            chk(e.name, "out_port1", out_port1,       e.op1);
            chk(e.name, "merr",      {31'd0, merr},   {31'd0, e.merr});
            if (e.chk_wmo) chk(e.name, "wmo", wmo, e.wmo);
        end
    end

    task automatic issue(input string nm, input logic rn_i, input logic wreg, input logic m2,
                         input logic wmem, input logic [31:0] alu, input logic [31:0] b,
                         input logic [4:0] rn, input logic chkm, input logic [31:0] ewmo,
                         input logic ewwreg, input logic [31:0] eop0, input logic [31:0] eop1,
                         input logic emerr);
        exp_t e;
        @(negedge clock);
        resetn = rn_i; mwreg = wreg; mm2reg = m2; mwmem = wmem;
        malu = alu; mb = b; mrn = rn;
        e.name    = nm;
        e.wwreg   = ewwreg;
        e.wm2reg  = rn_i ? m2  : 1'b0;
        e.walu    = rn_i ? alu : 32'd0;
        e.wrn     = rn_i ? rn  : 5'd0;
        e.chk_wmo = chkm;
        e.wmo     = ewmo;
        e.op0     = eop0;
        e.op1     = eop1;
        e.merr    = emerr;
        sb.push_back(e);
        @(posedge clock);
    endtask

    initial begin
        resetn = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        malu = 32'd0; mb = 32'd0; mrn = 5'd0;
        in_port0 = 32'h0000_1234;
        in_port1 = 32'h0000_CAFE;

        //     name        rstn wreg m2 wmem  malu          mb            rn  chk wmo           wwreg op0    op1    merr
        issue("reset0",     0,  0,  0, 0,  32'h0,        32'h0,        0,  1,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("reset1",     0,  1,  1, 0,  32'h4,        32'h0,        7,  1,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("st_w1",      1,  0,  0, 1,  32'h4,        32'hDEADBEEF, 0,  0,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("ld_w1",      1,  1,  1, 0,  32'h4,        32'h0,        5,  1,  32'hDEADBEEF, 1,    32'h0, 32'h0, 0);
        issue("st_w0",      1,  0,  0, 1,  32'h0,        32'h11,       0,  0,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("ld_alias",   1,  1,  1, 0,  32'h80000000, 32'h0,        3,  1,  32'h11,       1,    32'h0, 32'h0, 0);
        issue("st_op0",     1,  0,  0, 1,  32'h80,       32'h5A,       0,  1,  32'h0,        0,    32'h5A, 32'h0, 0);
        issue("st_op1",     1,  0,  0, 1,  32'h84,       32'hA5,       0,  1,  32'h0,        0,    32'h5A, 32'hA5, 0);
        issue("ld_in0",     1,  1,  1, 0,  32'h88,       32'h0,        9,  1,  32'h1234,     1,    32'h5A, 32'hA5, 0);
        issue("ld_in1",     1,  1,  1, 0,  32'h8C,       32'h0,        10, 1,  32'hCAFE,     1,    32'h5A, 32'hA5, 0);
        issue("st_ro",      1,  0,  0, 1,  32'h8C,       32'hFFFF,     0,  1,  32'hCAFE,     0,    32'h5A, 32'hA5, 0);
        issue("ld_op0",     1,  1,  1, 0,  32'h80,       32'h0,        11, 1,  32'h5A,       1,    32'h5A, 32'hA5, 0);
        issue("ld_op1",     1,  1,  0, 0,  32'h84,       32'h0,        12, 1,  32'hA5,       1,    32'h5A, 32'hA5, 0);
        issue("rst_st",     0,  1,  0, 1,  32'h80,       32'h77,       4,  1,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("ld_keep",    1,  1,  1, 0,  32'h4,        32'h0,        5,  1,  32'hDEADBEEF, 1,    32'h0, 32'h0, 0);
        issue("st_w2",      1,  0,  0, 1,  32'h8,        32'h1,        0,  0,  32'h0,        0,    32'h0, 32'h0, 0);
        issue("ld_w2",      1,  1,  1, 0,  32'h8,        32'h0,        6,  1,  32'h1,        1,    32'h0, 32'h0, 0);
        issue("st_w1b",     1,  0,  0, 1,  32'h4,        32'h22,       0,  1,  32'hDEADBEEF, 0,    32'h0, 32'h0, 0);
        issue("st_mis",     1,  1,  0, 1,  32'h6,        32'h99,       8,  1,  32'h22,       !c_trap, 32'h0, 32'h0, c_trap);
        issue("ld_after",   1,  1,  1, 0,  32'h4,        32'h0,        8,  1,  c_trap ? 32'h22 : 32'h99, 1, 32'h0, 32'h0, c_trap);
        issue("ld_mis",     1,  1,  1, 0,  32'h9,        32'h0,        13, 1,  32'h1,        !c_trap, 32'h0, 32'h0, c_trap);
        issue("st_mis_io",  1,  0,  0, 1,  32'h81,       32'h33,       0,  1,  32'h0,        0,    c_trap ? 32'h0 : 32'h33, 32'h0, c_trap);
        issue("reset_end",  0,  0,  0, 0,  32'h0,        32'h0,        0,  1,  32'h0,        0,    32'h0, 32'h0, 0);

        @(negedge clock);
        resetn = 1'b1; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipe_mem_wb_stage.md
Name: pipe_mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage pipelined CPU.
- Consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Performs the data-memory or memory-mapped I/O access and registers everything the WB stage needs, so load data (wmo) and the ALU result (walu) appear in the same cycle.

Parameters:
- DEPTH_LOG2, 5, log2 of data RAM depth in 32-bit words (default 32 words).
- IO_BIT, 7, address bit that selects the I/O space (1 = I/O, 0 = RAM).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- mwreg  input  1  instruction writes register file.
- mm2reg  input  1  instruction is a load (WB selects memory data).
- mwmem  input  1  instruction is a store.
- malu  input  32  ALU result; byte address for loads/stores.
- mb  input  32  store data.
- mrn  input  5  destination register number.
- in_port0  input  32  external input word 0, read-only at I/O offset 2.
- in_port1  input  32  external input word 1, read-only at I/O offset 3.
- wwreg  output  1  registered write-enable to WB.
- wm2reg  output  1  registered load select to WB.
- wmo  output  32  registered memory/I/O read data.
- walu  output  32  registered ALU result.
- wrn  output  5  registered destination register number.
- out_port0  output  32  I/O output register 0 (offset 0).
- out_port1  output  32  I/O output register 1 (offset 1).
- merr  output  1  sticky misalignment flag (see Optional Feature).

Behaviour:
- Latency: one cycle. Inputs presented in cycle N appear on W outputs after edge N.
- Decode:
  - io = malu[IO_BIT].
  - RAM index = malu[DEPTH_LOG2+1:2].
  - Address bits above the index, other than IO_BIT, are ignored; RAM aliases.
  - I/O offset = malu[3:2].
- Store (mwmem=1), rising edge:
  - io=0: RAM[index] <= mb.
  - io=1, offset 0: out_port0 <= mb. Offset 1: out_port1 <= mb. Offsets 2/3: write ignored.
- Read path: every cycle, wmo <= selected value, independent of mm2reg.
  - RAM: content before this edge's write (read-first).
  - I/O: offset 0 -> out_port0, 1 -> out_port1, 2 -> in_port0, 3 -> in_port1. Current register values are used; in_port values are sampled at the edge.
- Pipeline register: walu <= malu, wrn <= mrn, wm2reg <= mm2reg, wwreg <= mwreg (subject to Optional Feature).
- No stall or flush input: one instruction per cycle, so a store and a load never target the same word in the same cycle.
- Reset (resetn=0 at an edge):
  - wwreg, wm2reg, wmo, walu, wrn, out_port0, out_port1 and merr all go to 0.
  - A store presented in the reset cycle is discarded: no RAM or port write.
  - RAM contents are not cleared and are preserved across reset.
- X-safety: a RAM word never written reads as an undefined value; the bench must write before reading.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - If (mwmem or mm2reg) and malu[1:0] != 0, the store is suppressed (no RAM or port write).
  - In that case wwreg <= 0 for that instruction, and merr <= 1.
  - merr stays 1 until reset; it is not cleared by later aligned accesses.
  - wmo, walu, wrn and wm2reg update normally.
- Not defined:
  - malu[1:0] are ignored; access goes to the aligned word.
  - merr is constant 0.

Test Plan:
1. Reset, then store mb=0xDEADBEEF at malu=0x04, then load malu=0x04 with mwreg=1, mm2reg=1, mrn=5 -> on the load's result cycle: wmo=0xDEADBEEF, walu=0x04, wrn=5, wwreg=1, wm2reg=1.
2. Aliasing: store 0x11 at malu=0x00, then load malu=0x80000000 with IO_BIT=7 (bit7=0, RAM index 0) -> wmo=0x11.
3. I/O write: store 0x5A at malu=0x80, then 0xA5 at malu=0x84 -> out_port0=0x5A, out_port1=0xA5. Load 0x88 with in_port0=0x1234 -> wmo=0x1234. Store to 0x8C -> no port changes.
4. Store 0x77 to malu=0x80 in a cycle with resetn=0 -> out_port0 stays 0. All W outputs are 0 after that edge. Previously written RAM word 0x04 still reads 0xDEADBEEF.
5. Back-to-back: store 0x1 to 0x08, then immediately load 0x08 -> wmo=0x1 on the cycle after the load (no hazard).
6. With MISALIGN_TRAP_EN: store 0x99 to malu=0x06 with mwreg=1 -> RAM word 1 unchanged, wwreg=0, merr=1. Next aligned load -> merr stays 1. Without the macro: word 1 = 0x99, merr=0.
